tb_sim_ctrl: RTL and testbench
==============================

// Module: tb_sim_ctrl
// PURPOSE
//  Bench-side end-of-test controller for rv32i_soc simulations. Snoops NUM_CH core write
//  channels for a TOHOST store and counts cycles and retirements per channel. Flags timeout
//  and retire-stall hang, then drains a fixed number of cycles before pulsing o_finish so the
//  bench can dump memories, registers and waves and call $finish. Replaces fixed repeat(N) runs.
// PARAMETERS
//  NUM_CH          1             snooped write/retire channels (harts)
//  ADDR_W          32            snooped address width
//  DATA_W          32            snooped data width
//  CNT_W           32            counter width (all counters saturate)
//  TOHOST_ADDR     32'h0000_1000 byte address of the tohost word
//  TIMEOUT_CYCLES  100000        RUN cycles before forced fail
//  DRAIN_CYCLES    16            cycles from end-of-test detect to o_finish
// PORTS
//  clk           in   1             single clock
//  reset         in   1             synchronous, active-high
//  i_en          in   1             start/run enable (bench init done)
//  i_wr_vld      in   NUM_CH        per-channel store valid (one beat per cycle)
//  i_wr_addr     in   NUM_CH*ADDR_W per-channel store address, ch0 in LSBs
//  i_wr_data     in   NUM_CH*DATA_W per-channel store data
//  i_retire      in   NUM_CH        per-channel instruction retired (rvfi_valid)
//  o_running     out  1             state == RUN
//  o_done        out  1             state == DONE
//  o_pass        out  1             tohost end with exit code 0
//  o_exit_code   out  DATA_W-1      latched exit code
//  o_timeout     out  1             ended by TIMEOUT_CYCLES
//  o_hang        out  1             ended by retire-stall watchdog
//  o_finish      out  1             one-cycle pulse on entry to DONE
//  o_cycle_cnt   out  CNT_W         RUN cycles counted
//  o_retire_cnt  out  NUM_CH*CNT_W  retirements per channel
// BEHAVIOUR
//  - Reset values: all outputs 0; state IDLE; all counters 0. Reset mid-run returns to this at
//    the next edge.
//  - FSM IDLE->RUN when i_en=1. RUN->DRAIN on the first end event.
//    DRAIN->DONE after DRAIN_CYCLES edges; o_finish is high in the first DONE cycle only.
//    DONE holds until reset.
//  - In RUN with i_en=0, all counters and the watchdog freeze and the FSM stays in RUN.
//  - The cycle counter and retire counters count only in RUN && i_en. They saturate at
//    all-ones and do not wrap.
//  - TOHOST event: i_wr_vld[c] && addr==TOHOST_ADDR && data[0]==1 -> exit_code=data[DATA_W-1:1].
//    o_pass = (exit_code==0). Writes with data[0]==0 are ignored.
//  - Simultaneous TOHOST writes on several channels: the lowest channel index wins.
//  - Timeout: end event when o_cycle_cnt reaches TIMEOUT_CYCLES-1 while counting.
//    Sets o_timeout=1 and exit_code=all-ones.
//  - Priority in the same cycle: TOHOST > hang > timeout. Only one of pass/timeout/hang ever sets.
//  - Result flags and exit code latch at RUN->DRAIN. Counters freeze in DRAIN and DONE.
//    Events in DRAIN and DONE are ignored.
//  - Latency: TOHOST store at edge N -> o_running=0 at N+1 -> o_finish at N+1+DRAIN_CYCLES.
// CONFIGURATION
//  TB_SIM_CTRL_WDOG_EN defined:
//   - Per-channel stall counter resets on i_retire[c] and increments in RUN && i_en.
//   - When any channel reaches WDOG_CYCLES (localparam 1024), a hang end event fires.
//     It sets o_hang=1 and exit_code=all-ones-1.
//  TB_SIM_CTRL_WDOG_EN undefined:
//   - No stall counters are built and o_hang is tied to 0.
// STRUCTURE
//  - tb_sim_ctrl_pkg: sim_state_e {IDLE,RUN,DRAIN,DONE}, EXIT_TIMEOUT/EXIT_HANG constants,
//    end_cause_e {NONE,TOHOST,HANG,TIMEOUT}.
//  - Sub-module sat_counter #(CNT_W) with clr/inc/hold ports. It is instantiated for the cycle
//    counter, each retire counter and each watchdog counter.
// TESTING
//  1. NUM_CH=1; en at cyc 3; ch0 writes 0x1000 data 0x1 at cyc 50.
//     -> pass=1, exit_code=0, o_finish exactly at cyc 51+16.
//  2. TOHOST data 0xB (exit 5) -> pass=0, exit_code=5, timeout=0.
//     TOHOST write with data 0x4 -> ignored, FSM stays in RUN.
//  3. TIMEOUT_CYCLES=200, no TOHOST -> timeout=1, exit_code=all-ones, o_cycle_cnt=199.
//  4. NUM_CH=2; ch1 data 0x7 and ch0 data 0x3 in the same cycle -> exit_code=1 (ch0 wins).
//     TOHOST on the same edge as the timeout -> TOHOST result.
//  5. WDOG_EN; retire stops after 10 instrs -> hang=1 after 1024 stalled cycles,
//     o_retire_cnt=10. i_en low for 30 cyc in RUN -> counters are unchanged.
//  6. reset asserted in DRAIN -> next cycle all outputs 0, state IDLE. CNT_W=4 -> counter
//     holds at 15.

Source files
------------

// File: rtl/tb_sim_ctrl_pkg.sv
// Shared types and constants for the simulation end-of-test controller.
package tb_sim_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sim_state_e;

  typedef enum logic [1:0] {
    NONE,
    TOHOST,
    HANG,
    TIMEOUT
  } end_cause_e;

  // Wide patterns; the controller keeps the low DATA_W-1 bits.
  localparam logic [63:0] EXIT_TIMEOUT = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXIT_HANG    = 64'hFFFF_FFFF_FFFF_FFFE;

  localparam int WDOG_CYCLES = 1024;
  localparam int WDOG_W      = $clog2(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

endpackage

// File: rtl/tb_sim_ctrl_sat_counter.sv
// Saturating up-counter: clr wins, hold freezes, inc advances until all-ones.
module sat_counter
  import tb_sim_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_hold,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_hold && !(&r_cnt)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/tb_sim_ctrl.sv
// End-of-test controller: tohost snoop, timeout, optional retire-stall watchdog
// (enabled by defining TB_SIM_CTRL_WDOG_EN), then a fixed drain before o_finish.
module tb_sim_ctrl
  import tb_sim_ctrl_pkg::*;
#(
  parameter int              NUM_CH         = 1,
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter int              CNT_W          = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(32'h0000_1000),
  parameter int              TIMEOUT_CYCLES = 100000,
  parameter int              DRAIN_CYCLES   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_en,
  input  logic [NUM_CH-1:0]        i_wr_vld,
  input  logic [NUM_CH*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_wr_data,
  input  logic [NUM_CH-1:0]        i_retire,
  output logic                     o_running,
  output logic                     o_done,
  output logic                     o_pass,
  output logic [DATA_W-2:0]        o_exit_code,
  output logic                     o_timeout,
  output logic                     o_hang,
  output logic                     o_finish,
  output logic [CNT_W-1:0]         o_cycle_cnt,
  output logic [NUM_CH*CNT_W-1:0]  o_retire_cnt
);

  localparam int EXIT_W = DATA_W - 1;
  localparam int DRN_W  = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [63:0]       TO_LAST  = 64'(TIMEOUT_CYCLES - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [EXIT_W-1:0] W_EXIT_TIMEOUT = EXIT_TIMEOUT[EXIT_W-1:0];
  localparam logic [EXIT_W-1:0] W_EXIT_HANG    = EXIT_HANG[EXIT_W-1:0];

  sim_state_e        r_state;
  sim_state_e        w_state_nxt;
  end_cause_e        w_cause;
  logic              w_counting;
  logic              w_th_hit;
  logic              w_to_hit;
  logic              w_hang_hit;
  logic [EXIT_W-1:0] w_th_code;
  logic [EXIT_W-1:0] r_exit_code;
  logic [DRN_W-1:0]  r_drain_cnt;
  logic              r_pass;
  logic              r_timeout;
  logic              r_finish;
  logic [CNT_W-1:0]  w_cycle_cnt;

  assign w_counting = (r_state == RUN) && i_en;

  // Scan high to low so the lowest channel's write is the one that sticks.
  always_comb begin
    w_th_hit  = 1'b0;
    w_th_code = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (i_wr_vld[c] && (i_wr_addr[c*ADDR_W +: ADDR_W] == TOHOST_ADDR) &&
          i_wr_data[c*DATA_W]) begin
        w_th_hit  = 1'b1;
        w_th_code = i_wr_data[c*DATA_W+1 +: EXIT_W];
      end
    end
  end

  // The cycle counter parks at TIMEOUT_CYCLES-1; the next counted cycle ends the run.
  assign w_to_hit = w_counting && (64'(w_cycle_cnt) == TO_LAST);

`ifdef TB_SIM_CTRL_WDOG_EN
  logic [NUM_CH*WDOG_W-1:0] w_stall_cnt;
  logic [NUM_CH-1:0]        w_stall_hit;
  logic                     r_hang;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_wdog
    sat_counter #(.W(WDOG_W)) u_stall (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_counting && i_retire[g]),
      .i_inc  (1'b1),
      .i_hold (!w_counting),
      .o_cnt  (w_stall_cnt[g*WDOG_W +: WDOG_W])
    );
    // Fires on the WDOG_CYCLES-th consecutive counted cycle without a retirement.
    assign w_stall_hit[g] = w_counting && !i_retire[g] &&
                            (w_stall_cnt[g*WDOG_W +: WDOG_W] == WDOG_LAST);
  end

  assign w_hang_hit = |w_stall_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hang <= 1'b0;
    end else if (w_cause == HANG) begin
      r_hang <= 1'b1;
    end
  end

  assign o_hang = r_hang;
`else
  assign w_hang_hit = 1'b0;
  assign o_hang     = 1'b0;
`endif

  always_comb begin
    w_cause = NONE;
    if (w_counting) begin
      if (w_th_hit) begin
        w_cause = TOHOST;
      end else if (w_hang_hit) begin
        w_cause = HANG;
      end else if (w_to_hit) begin
        w_cause = TIMEOUT;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_en) w_state_nxt = RUN;
      RUN:     if (w_cause != NONE) w_state_nxt = DRAIN;
      DRAIN:   if (r_drain_cnt == DRN_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_exit_code <= '0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_finish    <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_finish <= (r_state == DRAIN) && (w_state_nxt == DONE);
      if (r_state == DRAIN) begin
        r_drain_cnt <= r_drain_cnt + DRN_W'(1);
      end
      if (w_cause != NONE) begin
        r_drain_cnt <= '0;
        r_pass      <= (w_cause == TOHOST) && (w_th_code == '0);
        r_timeout   <= (w_cause == TIMEOUT);
        case (w_cause)
          TOHOST:  r_exit_code <= w_th_code;
          HANG:    r_exit_code <= W_EXIT_HANG;
          default: r_exit_code <= W_EXIT_TIMEOUT;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (1'b0),
    .i_inc  (!w_to_hit),
    .i_hold (!w_counting),
    .o_cnt  (w_cycle_cnt)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_retire
    sat_counter #(.W(CNT_W)) u_retire (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (1'b0),
      .i_inc  (i_retire[g]),
      .i_hold (!w_counting),
      .o_cnt  (o_retire_cnt[g*CNT_W +: CNT_W])
    );
  end

  assign o_running   = (r_state == RUN);
  assign o_done      = (r_state == DONE);
  assign o_pass      = r_pass;
  assign o_timeout   = r_timeout;
  assign o_finish    = r_finish;
  assign o_exit_code = r_exit_code;
  assign o_cycle_cnt = w_cycle_cnt;

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Bench for tb_sim_ctrl: randomized snoop traffic against a cycle-level reference model,
// plus a 4-bit-counter instance sharing the same inputs for saturation checks.
module tb_tb_sim_ctrl;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 32;
  localparam int SAT_W   = 4;
  localparam int TIMEOUT = 1500;
  localparam int DRAIN   = 16;
  localparam int WDOG    = 1024;
  localparam logic [31:0] TOHOST    = 32'h0000_1000;
  localparam logic [30:0] EXIT_ALL1 = 31'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  vld = '0;
  logic [1:0]  retire = '0;
  logic [63:0] addr = '0;
  logic [63:0] data = '0;

  logic        running, done, pass, timeout, hang, finish;
  logic [30:0] exit_code;
  logic [31:0] cycle_cnt;
  logic [63:0] retire_cnt;
  logic        s_running, s_done, s_pass, s_timeout, s_hang, s_finish;
  logic [30:0] s_exit_code;
  logic [3:0]  s_cycle_cnt;
  logic [7:0]  s_retire_cnt;
  logic [5:0]  st;

  assign st = {running, done, pass, timeout, hang, finish};

  always #5 clk = ~clk;

  tb_sim_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT),
                .DRAIN_CYCLES(DRAIN)) u_dut (
    .clk(clk), .reset(reset), .i_en(en), .i_wr_vld(vld), .i_wr_addr(addr),
    .i_wr_data(data), .i_retire(retire), .o_running(running), .o_done(done),
    .o_pass(pass), .o_exit_code(exit_code), .o_timeout(timeout), .o_hang(hang),
    .o_finish(finish), .o_cycle_cnt(cycle_cnt), .o_retire_cnt(retire_cnt)
  );

  tb_sim_ctrl #(.NUM_CH(NUM_CH), .CNT_W(SAT_W), .TIMEOUT_CYCLES(TIMEOUT),
                .DRAIN_CYCLES(DRAIN)) u_sat (
    .clk(clk), .reset(reset), .i_en(en), .i_wr_vld(vld), .i_wr_addr(addr),
    .i_wr_data(data), .i_retire(retire), .o_running(s_running), .o_done(s_done),
    .o_pass(s_pass), .o_exit_code(s_exit_code), .o_timeout(s_timeout), .o_hang(s_hang),
    .o_finish(s_finish), .o_cycle_cnt(s_cycle_cnt), .o_retire_cnt(s_retire_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: run phase flags, counts, and edges elapsed since the end event.
  bit          m_started, m_ended, m_pass, m_to, m_hang;
  int          m_since, m_cycles;
  int          m_ret[NUM_CH];
  int          m_stall[NUM_CH];
  logic [30:0] m_exit;

  function automatic void model_reset();
    m_started = 0; m_ended = 0; m_pass = 0; m_to = 0; m_hang = 0;
    m_since = 0; m_cycles = 0; m_exit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_ret[c] = 0;
      m_stall[c] = 0;
    end
  endfunction

  function automatic logic [5:0] exp_status();
    return {m_started && !m_ended, m_ended && (m_since >= DRAIN), m_pass, m_to, m_hang,
            m_ended && (m_since == DRAIN)};
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Applies the current inputs to the model, then advances one clock.
  task automatic tick();
    int th;
    bit hg;
    th = -1;
    hg = 0;
    if (reset) begin
      model_reset();
    end else if (!m_started) begin
      m_started = en;
    end else if (!m_ended) begin
      if (en) begin
        for (int c = 0; c < NUM_CH; c++)
          if (th < 0 && vld[c] && addr[c*32 +: 32] == TOHOST && data[c*32]) th = c;
`ifdef TB_SIM_CTRL_WDOG_EN
        for (int c = 0; c < NUM_CH; c++)
          if (!retire[c] && m_stall[c] == WDOG - 1) hg = 1;
`endif
        if (th >= 0) begin
          m_ended = 1; m_exit = data[th*32+1 +: 31]; m_pass = (m_exit == 0);
        end else if (hg) begin
          m_ended = 1; m_hang = 1; m_exit = EXIT_ALL1 - 31'd1;
        end else if (m_cycles == TIMEOUT - 1) begin
          m_ended = 1; m_to = 1; m_exit = EXIT_ALL1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
          m_ret[c] += int'(retire[c]);
          m_stall[c] = retire[c] ? 0 : m_stall[c] + 1;
        end
        if (m_cycles < TIMEOUT - 1) m_cycles++;
      end
    end else if (m_since < 1000) begin
      m_since++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      logic [31:0] a, d;
      a = ($urandom_range(0, 3) == 0) ? TOHOST : $urandom;
      d = $urandom;
      if (a == TOHOST) d[0] = 1'b0;
      vld[c] = 1'($urandom_range(0, 1));
      addr[c*32 +: 32] = a;
      data[c*32 +: 32] = d;
      retire[c] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic put_tohost(input int ch, input logic [31:0] d);
    vld[ch] = 1'b1;
    addr[ch*32 +: 32] = TOHOST;
    data[ch*32 +: 32] = d;
  endtask

  task automatic apply_reset();
    reset = 1'b1; en = 1'b0; vld = '0; retire = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (st !== 6'b0) begin n_errors++; $display("FAIL reset_status: got %b expected %b", st, 6'b0); end
    n_checks++; if (exit_code !== 31'd0) begin n_errors++; $display("FAIL reset_exit: got %0h expected 0", exit_code); end
    n_checks++; if (cycle_cnt !== 32'd0 || retire_cnt !== 64'd0) begin n_errors++; $display("FAIL reset_counters: got %0d/%0h expected 0/0", cycle_cnt, retire_cnt); end
    n_checks++; if (s_cycle_cnt !== 4'd0 || s_retire_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_sat_counters: got %0d/%0h expected 0/0", s_cycle_cnt, s_retire_cnt); end
  endtask

  task automatic test_pass();
    int fin_at;
    fin_at = -1;
    apply_reset();
    for (int cyc = 0; cyc < 50; cyc++) begin
      en = (cyc >= 3);
      rand_inputs();
      tick();
    end
    rand_inputs();
    put_tohost(0, 32'h1);
    tick();
    n_checks++; if (st !== exp_status()) begin n_errors++; $display("FAIL pass_status: got %b expected %b", st, exp_status()); end
    n_checks++; if (pass !== 1'b1 || exit_code !== 31'd0) begin n_errors++; $display("FAIL pass_result: got pass=%b exit=%0h expected pass=1 exit=0", pass, exit_code); end
    n_checks++; if (cycle_cnt !== 32'(m_cycles)) begin n_errors++; $display("FAIL pass_cycles: got %0d expected %0d", cycle_cnt, m_cycles); end
    n_checks++; if (retire_cnt !== {32'(m_ret[1]), 32'(m_ret[0])}) begin n_errors++; $display("FAIL pass_retires: got %0h expected %0d/%0d", retire_cnt, m_ret[1], m_ret[0]); end
    n_checks++; if (s_cycle_cnt !== 4'd15 || s_retire_cnt !== {4'(sat15(m_ret[1])), 4'(sat15(m_ret[0]))}) begin n_errors++; $display("FAIL pass_saturation: got %0d/%0h expected 15/%0d/%0d", s_cycle_cnt, s_retire_cnt, sat15(m_ret[1]), sat15(m_ret[0])); end
    // Keep writing failing tohost values during drain; they must be ignored.
    for (int k = 1; k <= DRAIN + 2; k++) begin
      rand_inputs();
      put_tohost(0, 32'hB);
      tick();
      if (finish === 1'b1 && fin_at < 0) fin_at = k;
      n_checks++; if (st !== exp_status() || exit_code !== 31'd0) begin n_errors++; $display("FAIL drain_status k=%0d: got %b exit=%0h expected %b exit=0", k, st, exit_code, exp_status()); end
    end
    n_checks++; if (fin_at !== DRAIN) begin n_errors++; $display("FAIL finish_latency: got %0d expected %0d", fin_at, DRAIN); end
    n_checks++; if (cycle_cnt !== 32'(m_cycles)) begin n_errors++; $display("FAIL done_cycles_frozen: got %0d expected %0d", cycle_cnt, m_cycles); end
  endtask

  task automatic test_exit_code();
    apply_reset();
    en = 1'b1;
    repeat (20) begin rand_inputs(); tick(); end
    rand_inputs();
    put_tohost(0, 32'h4);
    tick();
    n_checks++; if (running !== 1'b1 || st !== exp_status()) begin n_errors++; $display("FAIL even_tohost_ignored: got %b expected %b", st, exp_status()); end
    repeat (5) begin rand_inputs(); tick(); end
    rand_inputs();
    addr[31:0] = 32'h0000_2000;
    put_tohost(1, 32'hB);
    tick();
    n_checks++; if (st !== exp_status()) begin n_errors++; $display("FAIL exit5_status: got %b expected %b", st, exp_status()); end
    n_checks++; if (exit_code !== 31'd5 || pass !== 1'b0 || timeout !== 1'b0) begin n_errors++; $display("FAIL exit5_result: got exit=%0h pass=%b timeout=%b expected 5/0/0", exit_code, pass, timeout); end
  endtask

  task automatic test_timeout();
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < TIMEOUT + 50 && !m_ended; i++) begin rand_inputs(); tick(); end
    n_checks++; if (st !== exp_status()) begin n_errors++; $display("FAIL timeout_status: got %b expected %b", st, exp_status()); end
    n_checks++; if (timeout !== 1'b1 || exit_code !== EXIT_ALL1) begin n_errors++; $display("FAIL timeout_result: got to=%b exit=%0h expected 1/%0h", timeout, exit_code, EXIT_ALL1); end
    n_checks++; if (cycle_cnt !== 32'(TIMEOUT - 1)) begin n_errors++; $display("FAIL timeout_cycles: got %0d expected %0d", cycle_cnt, TIMEOUT - 1); end
    n_checks++; if (retire_cnt !== {32'(m_ret[1]), 32'(m_ret[0])}) begin n_errors++; $display("FAIL timeout_retires: got %0h expected %0d/%0d", retire_cnt, m_ret[1], m_ret[0]); end
    n_checks++; if (s_cycle_cnt !== 4'd15 || s_retire_cnt !== {4'(sat15(m_ret[1])), 4'(sat15(m_ret[0]))}) begin n_errors++; $display("FAIL sat_hold: got %0d/%0h expected 15/%0d/%0d", s_cycle_cnt, s_retire_cnt, sat15(m_ret[1]), sat15(m_ret[0])); end
    repeat (DRAIN + 3) begin rand_inputs(); tick(); end
    n_checks++; if (st !== exp_status() || cycle_cnt !== 32'(TIMEOUT - 1)) begin n_errors++; $display("FAIL timeout_done: got %b cyc=%0d expected %b cyc=%0d", st, cycle_cnt, exp_status(), TIMEOUT - 1); end
  endtask

  task automatic test_priority();
    apply_reset();
    en = 1'b1;
    repeat (10) begin rand_inputs(); tick(); end
    rand_inputs();
    put_tohost(1, 32'h7);
    put_tohost(0, 32'h3);
    tick();
    n_checks++; if (exit_code !== 31'd1 || st !== exp_status()) begin n_errors++; $display("FAIL lowest_channel: got exit=%0h st=%b expected exit=1 st=%b", exit_code, st, exp_status()); end
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < TIMEOUT + 50 && m_cycles < TIMEOUT - 1; i++) begin rand_inputs(); tick(); end
    n_checks++; if (running !== 1'b1 || cycle_cnt !== 32'(TIMEOUT - 1)) begin n_errors++; $display("FAIL pre_timeout: got run=%b cyc=%0d expected 1/%0d", running, cycle_cnt, TIMEOUT - 1); end
    rand_inputs();
    addr[31:0] = 32'h0000_2000;
    put_tohost(1, 32'h5);
    tick();
    n_checks++; if (st !== exp_status() || exit_code !== 31'd2 || timeout !== 1'b0) begin n_errors++; $display("FAIL tohost_over_timeout: got st=%b exit=%0h expected st=%b exit=2", st, exit_code, exp_status()); end
  endtask

  task automatic test_en_freeze();
    apply_reset();
    en = 1'b1;
    repeat (40) begin rand_inputs(); tick(); end
    en = 1'b0;
    repeat (30) begin rand_inputs(); tick(); end
    n_checks++; if (running !== 1'b1 || cycle_cnt !== 32'(m_cycles) || m_cycles !== 39) begin n_errors++; $display("FAIL freeze_cycles: got run=%b cyc=%0d expected 1/%0d", running, cycle_cnt, m_cycles); end
    n_checks++; if (retire_cnt !== {32'(m_ret[1]), 32'(m_ret[0])}) begin n_errors++; $display("FAIL freeze_retires: got %0h expected %0d/%0d", retire_cnt, m_ret[1], m_ret[0]); end
    en = 1'b1;
    repeat (5) begin rand_inputs(); tick(); end
    n_checks++; if (cycle_cnt !== 32'd44) begin n_errors++; $display("FAIL resume_cycles: got %0d expected 44", cycle_cnt); end
  endtask

  task automatic test_hang();
    int n_stall;
    n_stall = 0;
    apply_reset();
    en = 1'b1;
    tick();
    retire = 2'b11;
    repeat (10) tick();
    retire = 2'b00;
`ifdef TB_SIM_CTRL_WDOG_EN
    for (int i = 0; i < 1300 && running; i++) begin
      en = !(i >= 100 && i < 130);
      tick();
      if (en) n_stall++;
    end
    n_checks++; if (n_stall !== WDOG) begin n_errors++; $display("FAIL hang_latency: got %0d expected %0d", n_stall, WDOG); end
    n_checks++; if (hang !== 1'b1 || exit_code !== EXIT_ALL1 - 31'd1 || st !== exp_status()) begin n_errors++; $display("FAIL hang_result: got st=%b exit=%0h expected st=%b exit=%0h", st, exit_code, exp_status(), EXIT_ALL1 - 31'd1); end
`else
    for (int i = 0; i < 1100; i++) begin tick(); n_stall++; end
    n_checks++; if (hang !== 1'b0 || running !== 1'b1 || st !== exp_status()) begin n_errors++; $display("FAIL no_wdog: got st=%b after %0d stalls expected %b", st, n_stall, exp_status()); end
`endif
    n_checks++; if (retire_cnt !== {32'd10, 32'd10}) begin n_errors++; $display("FAIL hang_retires: got %0h expected 10/10", retire_cnt); end
  endtask

  task automatic test_reset_drain();
    apply_reset();
    en = 1'b1;
    repeat (20) begin rand_inputs(); tick(); end
    rand_inputs();
    put_tohost(0, 32'h1);
    tick();
    repeat (5) begin rand_inputs(); tick(); end
    n_checks++; if (st !== exp_status() || st !== 6'b001000) begin n_errors++; $display("FAIL in_drain: got %b expected %b", st, exp_status()); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en = 1'b0;
    n_checks++; if (st !== 6'b0 || exit_code !== 31'd0) begin n_errors++; $display("FAIL drain_reset_outputs: got %b exit=%0h expected 0", st, exit_code); end
    n_checks++; if (cycle_cnt !== 32'd0 || retire_cnt !== 64'd0 || s_cycle_cnt !== 4'd0 || s_retire_cnt !== 8'd0) begin n_errors++; $display("FAIL drain_reset_counters: got %0d/%0h expected 0/0", cycle_cnt, retire_cnt); end
    tick();
    n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL idle_hold: got %b expected 0", running); end
    en = 1'b1;
    tick();
    n_checks++; if (running !== 1'b1 || st !== exp_status()) begin n_errors++; $display("FAIL restart: got %b expected %b", st, exp_status()); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass();
    test_exit_code();
    test_timeout();
    test_priority();
    test_en_freeze();
    test_hang();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got no end of run expected finish before 2ms");
    $fatal(1);
  end

endmodule
